// File: rtl/mips_alu_hilo_iter.sv
// ============================================================================
//  Module      : mips_alu_hilo_iter
//  Description : Iterative MIPS multiply/divide unit owning the HI/LO registers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_alu_hilo_iter #(
    parameter int DATA_W = 32,
    parameter int STEP   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        func,
    input  logic [DATA_W-1:0] data1,
    input  logic [DATA_W-1:0] data2,
    input  logic              cancel,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              busy,
    output logic              stall,
    output logic              done
);
    localparam int ITERS = DATA_W / STEP;
    localparam int CNT_W = $clog2(ITERS) + 1;

    localparam logic [3:0] FUNC_MULU = 4'h8;
    localparam logic [3:0] FUNC_MULS = 4'h9;
    localparam logic [3:0] FUNC_DIVU = 4'hA;
    localparam logic [3:0] FUNC_DIVS = 4'hB;
    localparam logic [3:0] FUNC_MTHI = 4'hC;
    localparam logic [3:0] FUNC_MTLO = 4'hD;
    localparam logic [3:0] FUNC_MFHI = 4'hE;
    localparam logic [3:0] FUNC_MFLO = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2*DATA_W-1:0] acc_q, acc_d;     // mul: {hi,lo} partial; div: {rem,quo}
    logic [DATA_W-1:0]   opb_q, opb_d;     // multiplicand or divisor magnitude
    logic                is_div_q, is_div_d;
    logic                neg_lo_q, neg_lo_d;
    logic                neg_hi_q, neg_hi_d;
    logic                div0_q, div0_d;
    logic [DATA_W-1:0]   hi_q, hi_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic                done_q, done_d;

    logic                w_is_mul, w_is_div, w_is_signed, w_is_hilo;
    logic                w_a_neg, w_b_neg;
    logic [DATA_W-1:0]   w_a_mag, w_b_mag;
    logic [2*DATA_W-1:0] w_step_acc;
    logic [DATA_W:0]     w_sum, w_trial;
    logic [2*DATA_W-1:0] w_prod;
    logic [DATA_W-1:0]   w_quo, w_rem;

    always_comb begin
        w_is_mul    = (func == FUNC_MULU) || (func == FUNC_MULS);
        w_is_div    = (func == FUNC_DIVU) || (func == FUNC_DIVS);
        w_is_signed = (func == FUNC_MULS) || (func == FUNC_DIVS);
        w_is_hilo   = w_is_mul || w_is_div || (func == FUNC_MTHI) || (func == FUNC_MTLO)
                      || (func == FUNC_MFHI) || (func == FUNC_MFLO);
        w_a_neg     = w_is_signed & data1[DATA_W-1];
        w_b_neg     = w_is_signed & data2[DATA_W-1];
        w_a_mag     = w_a_neg ? -data1 : data1;
        w_b_mag     = w_b_neg ? -data2 : data2;
    end

    // One iteration retires STEP bits: shift-add multiply or restoring divide
    always_comb begin
        w_step_acc = acc_q;
        w_sum      = '0;
        w_trial    = '0;
        for (int i = 0; i < STEP; i++) begin
            if (is_div_q) begin
                w_trial = w_step_acc[2*DATA_W-1:DATA_W-1] - {1'b0, opb_q};
                if (!w_trial[DATA_W]) begin
                    w_step_acc = {w_trial[DATA_W-1:0], w_step_acc[DATA_W-2:0], 1'b1};
                end else begin
                    w_step_acc = {w_step_acc[2*DATA_W-2:0], 1'b0};
                end
            end else begin
                w_sum = {1'b0, w_step_acc[2*DATA_W-1:DATA_W]}
                        + (w_step_acc[0] ? {1'b0, opb_q} : {(DATA_W+1){1'b0}});
                w_step_acc = {w_sum, w_step_acc[DATA_W-1:1]};
            end
        end
    end

    always_comb begin
        w_prod = neg_lo_q ? -acc_q : acc_q;
        w_quo  = div0_q ? {DATA_W{1'b1}}
                        : (neg_lo_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0]);
        // A zero divisor leaves the dividend magnitude here, so the sign fix restores data1
        w_rem  = neg_hi_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        div0_d   = div0_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !cancel) begin
                    if (w_is_mul || w_is_div) begin
                        state_d  = ST_RUN;
                        cnt_d    = CNT_W'(ITERS);
                        acc_d    = {{DATA_W{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
                        opb_d    = w_is_div ? w_b_mag : w_a_mag;
                        is_div_d = w_is_div;
                        neg_lo_d = w_a_neg ^ w_b_neg;
                        neg_hi_d = w_a_neg;
                        div0_d   = (data2 == '0);
                    end else if (func == FUNC_MTHI) begin
                        hi_d = data1;
                    end else if (func == FUNC_MTLO) begin
                        lo_d = data1;
                    end
                end
            end
            ST_RUN: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                end else begin
                    acc_d = w_step_acc;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_FIX;
                    end
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                if (!cancel) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        hi_d = w_rem;
                        lo_d = w_quo;
                    end else begin
                        {hi_d, lo_d} = w_prod;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            div0_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            div0_q   <= div0_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        result = '0;
        if (func == FUNC_MFHI) begin
            result = hi_q;
        end else if (func == FUNC_MFLO) begin
            result = lo_q;
        end
        zero  = (result == '0);
        busy  = (state_q != ST_IDLE);
        stall = busy & start & w_is_hilo;
        done  = done_q;
    end

endmodule

`default_nettype wire
